// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, fetch line size,
// controller length width and the default starvation-guard limit.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_IF,
    ST_BUSY_LD,
    ST_BUSY_ST,
    ST_DRAIN
  } state_t;

  localparam int DEF_IF_LINE_BYTES = 16;
  localparam int MC_LEN_W          = 5;
  localparam int DEF_MAX_WAIT      = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto a single byte-serial memory controller.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int ADDR_W        = 32,
  parameter  int DATA_W        = 32,
  parameter  int IF_LINE_BYTES = DEF_IF_LINE_BYTES,
  parameter  int MAX_WAIT      = DEF_MAX_WAIT,
  localparam int IF_DATA_W     = 8 * IF_LINE_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_done,
  output logic [IF_DATA_W-1:0] if_data,
  input  logic                 lsb_req,
  input  logic                 lsb_rw,
  input  logic [ADDR_W-1:0]    lsb_addr,
  input  logic [2:0]           lsb_len,
  input  logic [DATA_W-1:0]    lsb_wdata,
  output logic                 lsb_done,
  output logic [DATA_W-1:0]    lsb_rdata,
  output logic                 mc_en,
  output logic                 mc_rw,
  output logic [ADDR_W-1:0]    mc_addr,
  output logic [MC_LEN_W-1:0]  mc_len,
  output logic [DATA_W-1:0]    mc_wdata,
  input  logic                 mc_done,
  input  logic [DATA_W-1:0]    mc_rdata,
  input  logic [IF_DATA_W-1:0] mc_if_data
);

  state_t                state_q, state_d;
  logic                  gap_q, gap_d;
  logic                  mc_en_d, mc_rw_d;
  logic [ADDR_W-1:0]     mc_addr_d;
  logic [MC_LEN_W-1:0]   mc_len_d;
  logic [DATA_W-1:0]     mc_wdata_d;
  logic                  if_done_d, lsb_done_d;
  logic [IF_DATA_W-1:0]  if_data_d;
  logic [DATA_W-1:0]     lsb_rdata_d;
  logic                  starve, grant, pick_if;

  assign grant   = rdy && (state_q == ST_IDLE) && !gap_q && !rollback && (if_req || lsb_req);
  assign pick_if = if_req && (!lsb_req || starve);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign starve = (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (rdy) begin
      if (rollback)                    wait_d = '0;
      else if (grant && pick_if)       wait_d = '0;
      else if (grant && if_req && !starve) wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    gap_d       = gap_q;
    mc_en_d     = mc_en;
    mc_rw_d     = mc_rw;
    mc_addr_d   = mc_addr;
    mc_len_d    = mc_len;
    mc_wdata_d  = mc_wdata;
    if_data_d   = if_data;
    lsb_rdata_d = lsb_rdata;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;

    if (rdy) begin
      if (state_q == ST_IDLE) begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (grant) begin
          mc_en_d = 1'b1;
          if (pick_if) begin
            mc_rw_d    = 1'b0;
            mc_addr_d  = if_addr;
            mc_len_d   = MC_LEN_W'(IF_LINE_BYTES);
            mc_wdata_d = '0;
            state_d    = ST_BUSY_IF;
          end else begin
            mc_rw_d    = lsb_rw;
            mc_addr_d  = lsb_addr;
            mc_len_d   = MC_LEN_W'(lsb_len);
            mc_wdata_d = lsb_wdata;
            state_d    = lsb_rw ? ST_BUSY_ST : ST_BUSY_LD;
          end
        end
      end else if (mc_done) begin
        state_d    = ST_IDLE;
        gap_d      = 1'b1;
        mc_en_d    = 1'b0;
        mc_rw_d    = 1'b0;
        mc_addr_d  = '0;
        mc_len_d   = '0;
        mc_wdata_d = '0;
        // Committed stores always report; squashed reads report nothing.
        if (state_q == ST_BUSY_ST) begin
          lsb_done_d = 1'b1;
        end else if (!rollback && state_q == ST_BUSY_IF) begin
          if_done_d = 1'b1;
          if_data_d = mc_if_data;
        end else if (!rollback && state_q == ST_BUSY_LD) begin
          lsb_done_d  = 1'b1;
          lsb_rdata_d = mc_rdata;
        end
      end else if (rollback && (state_q == ST_BUSY_IF || state_q == ST_BUSY_LD)) begin
        state_d = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= 1'b0;
      mc_en     <= 1'b0;
      mc_rw     <= 1'b0;
      mc_addr   <= '0;
      mc_len    <= '0;
      mc_wdata  <= '0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      if_data   <= '0;
      lsb_rdata <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      mc_en     <= mc_en_d;
      mc_rw     <= mc_rw_d;
      mc_addr   <= mc_addr_d;
      mc_len    <= mc_len_d;
      mc_wdata  <= mc_wdata_d;
      if_done   <= if_done_d;
      lsb_done  <= lsb_done_d;
      if_data   <= if_data_d;
      lsb_rdata <= lsb_rdata_d;
    end
  end

  a_max_wait: assert property (@(posedge clk) MAX_WAIT > 0);

  a_lsb_len: assert property (@(posedge clk) disable iff (rst)
    (grant && !pick_if) |-> (lsb_len inside {3'd1, 3'd2, 3'd4}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, rdy, rollback;
  logic         if_req, if_done, lsb_req, lsb_rw, lsb_done;
  logic [31:0]  if_addr, lsb_addr, lsb_wdata, lsb_rdata;
  logic [2:0]   lsb_len;
  logic [127:0] if_data, mc_if_data;
  logic         mc_en, mc_rw, mc_done;
  logic [31:0]  mc_addr, mc_wdata, mc_rdata;
  logic [4:0]   mc_len;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int           streak;
  logic [127:0] exp_if_data;
  logic [31:0]  exp_lsb_rdata;
  bit           g_if, g_rw;
  logic [31:0]  g_addr, g_wdata;
  logic [4:0]   g_len;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_rw(lsb_rw), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mc_en(mc_en), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata), .mc_if_data(mc_if_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_mc_en"},     mc_en,     '0);
    check({tag, "_mc_rw"},     mc_rw,     '0);
    check({tag, "_mc_addr"},   mc_addr,   '0);
    check({tag, "_mc_len"},    mc_len,    '0);
    check({tag, "_mc_wdata"},  mc_wdata,  '0);
    check({tag, "_if_done"},   if_done,   '0);
    check({tag, "_lsb_done"},  lsb_done,  '0);
    check({tag, "_if_data"},   if_data,   '0);
    check({tag, "_lsb_rdata"}, lsb_rdata, '0);
  endtask

  function automatic logic [2:0] rand_len();
    case ($urandom % 3)
      0:       return 3'd1;
      1:       return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  task automatic raise_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic raise_lsb(input bit rw, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] wd);
    lsb_req   = 1'b1;
    lsb_rw    = rw;
    lsb_addr  = a;
    lsb_len   = len;
    lsb_wdata = rw ? wd : 32'h0;
  endtask

  task automatic raise_random();
    if (!if_req && ($urandom % 2 == 1)) raise_if($urandom & 32'hFFFF_FFF0);
    if (!lsb_req && (($urandom % 2 == 1) || !if_req))
      raise_lsb(1'($urandom % 2), $urandom, rand_len(), $urandom);
  endtask

  // Pipeline flush: fetch and pending loads are withdrawn, stores stay.
  task automatic flush();
    if_req = 1'b0;
    if (lsb_req && !lsb_rw) lsb_req = 1'b0;
    streak = 0;
  endtask

  // Predict the winner from the held requests, step to the grant edge, compare.
  task automatic grant_check(input string tag);
    g_if = if_req && (!lsb_req || (GUARD && streak == MAX_WAIT));
    if (g_if) begin
      g_rw = 1'b0; g_addr = if_addr; g_len = 5'd16; g_wdata = 32'h0;
      streak = 0;
    end else begin
      g_rw = lsb_rw; g_addr = lsb_addr; g_len = {2'b00, lsb_len}; g_wdata = lsb_wdata;
      if (if_req && streak < MAX_WAIT) streak++;
    end
    tick();
    check({tag, "_en"},    mc_en,    1'b1);
    check({tag, "_rw"},    mc_rw,    g_rw);
    check({tag, "_addr"},  mc_addr,  g_addr);
    check({tag, "_len"},   mc_len,   g_len);
    check({tag, "_wdata"}, mc_wdata, g_wdata);
  endtask

  // Act as the controller: hold for lat cycles, then pulse mc_done.
  // rb_at selects the busy cycle carrying rollback (lat = same cycle as mc_done, -1 = none).
  task automatic serve(input int lat, input int rb_at, input logic [31:0] rd, input logic [127:0] line);
    bit squashed = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (k == rb_at) begin
        rollback = 1'b1;
        if (!g_rw) squashed = 1'b1;
        flush();
      end
      tick();
      rollback = 1'b0;
      check("busy_en",    mc_en,    1'b1);
      check("busy_addr",  mc_addr,  g_addr);
      check("busy_len",   mc_len,   g_len);
      check("busy_wdata", mc_wdata, g_wdata);
      check("busy_done",  {if_done, lsb_done}, 2'b00);
    end
    mc_done    = 1'b1;
    mc_rdata   = rd;
    mc_if_data = line;
    if (rb_at == lat) begin
      rollback = 1'b1;
      if (!g_rw) squashed = 1'b1;
      flush();
    end
    tick();
    mc_done  = 1'b0;
    rollback = 1'b0;
    if (!squashed) begin
      if (g_if)       exp_if_data   = line;
      else if (!g_rw) exp_lsb_rdata = rd;
    end
    check("done_if",   if_done,   !squashed && g_if);
    check("done_lsb",  lsb_done,  !squashed && !g_if);
    check("if_data",   if_data,   exp_if_data);
    check("lsb_rdata", lsb_rdata, exp_lsb_rdata);
    check("rel_en",    mc_en,     1'b0);
    check("rel_fields", {mc_rw, mc_addr, mc_len, mc_wdata}, '0);
    if (!squashed) begin
      if (g_if) if_req  = 1'b0;
      else      lsb_req = 1'b0;
    end
    tick();
    check("gap_en",   mc_en, 1'b0);
    check("gap_done", {if_done, lsb_done}, 2'b00);
  endtask

  initial begin
    logic [127:0] line;
    int lat, rb;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; mc_done = 1'b0;
    if_req = 1'b0; if_addr = '0; lsb_req = 1'b0; lsb_rw = 1'b0;
    lsb_addr = '0; lsb_len = 3'd4; lsb_wdata = '0;
    mc_rdata = '0; mc_if_data = '0;
    streak = 0; exp_if_data = '0; exp_lsb_rdata = '0;

    repeat (2) tick();
    reset_check("rst");
    rst = 1'b0;

    // Fetch only, 16-byte line
    for (int i = 0; i < 16; i++) line[i*8 +: 8] = 8'(i);
    raise_if(32'h100);
    grant_check("t1");
    serve(17, -1, 32'h0, line);
    check("t1_line", if_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Load wins over fetch; fetch granted two edges after the load's mc_done
    raise_lsb(1'b0, 32'h2000, 3'd4, 32'h0);
    raise_if(32'h140);
    grant_check("t2_ld");
    serve(5, -1, 32'hDEAD_BEEF, {4{$urandom}});
    check("t2_rdata", lsb_rdata, 32'hDEAD_BEEF);
    grant_check("t2_if");
    serve(3, -1, $urandom, {4{$urandom}});

    // Rollback three cycles into a load
    raise_lsb(1'b0, 32'h2004, 3'd4, 32'h0);
    grant_check("t3_ld");
    serve(6, 3, $urandom, {4{$urandom}});
    raise_if(32'h180);
    grant_check("t3_next");
    serve(2, -1, $urandom, {4{$urandom}});

    // Rollback during a store is ignored
    raise_lsb(1'b1, 32'h30000, 3'd2, 32'h1234);
    grant_check("t4_st");
    serve(5, 2, $urandom, {4{$urandom}});

    // Fetch held against a continuously loaded LSB
    raise_if(32'h4000);
    for (int n = 0; n < 10; n++) begin
      if (!lsb_req) raise_lsb(1'b0, 32'h5000 + 32'(n * 4), 3'd4, 32'h0);
      grant_check("t5");
      check("t5_fetch_won", mc_addr == 32'h4000, GUARD && n == 8);
      serve(1, -1, $urandom, {4{$urandom}});
    end

    // Asynchronous reset between edges during a fetch
    lsb_req = 1'b0;
    if (!if_req) raise_if(32'h6000);
    grant_check("t6");
    tick();
    tick();
    #2 rst = 1'b1;
    #1 reset_check("t6_async");
    tick();
    #2 rst = 1'b0;
    streak = 0; exp_if_data = '0; exp_lsb_rdata = '0;
    grant_check("t6_regrant");
    serve(4, -1, $urandom, {4{$urandom}});

    // rdy low freezes grants and completions, but done pulses still clear
    raise_lsb(1'b0, 32'h7000, 3'd4, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_no_grant", mc_en, 1'b0);
    end
    rdy = 1'b1;
    grant_check("rdy_ld");
    rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1111_1111;
    tick();
    mc_done = 1'b0;
    check("rdy_hold_en",   mc_en,    1'b1);
    check("rdy_hold_done", lsb_done, 1'b0);
    rdy = 1'b1; mc_done = 1'b1; mc_rdata = 32'hA5A5_0F0F;
    tick();
    mc_done = 1'b0; rdy = 1'b0;
    exp_lsb_rdata = 32'hA5A5_0F0F;
    check("rdy_done",  lsb_done,  1'b1);
    check("rdy_rdata", lsb_rdata, exp_lsb_rdata);
    lsb_req = 1'b0;
    raise_if(32'h7100);
    tick();
    check("rdy_done_clear", lsb_done, 1'b0);
    check("rdy_gap_en",     mc_en,    1'b0);
    tick();
    check("rdy_gap_held", mc_en, 1'b0);
    rdy = 1'b1;
    tick();
    check("rdy_gap_clear", mc_en, 1'b0);
    grant_check("rdy_if");
    serve(2, -1, $urandom, {4{$urandom}});

    // Rollback while idle blocks that cycle's grant
    raise_lsb(1'b0, 32'h7200, 3'd1, 32'h0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    streak = 0;
    check("idle_rb_no_grant", mc_en, 1'b0);
    grant_check("idle_rb");
    serve(1, -1, $urandom, {4{$urandom}});

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      raise_random();
      grant_check("rnd");
      lat = 1 + int'($urandom % 6);
      rb  = ($urandom % 4 == 0) ? int'($urandom % (lat + 1)) : -1;
      serve(lat, rb, $urandom, {4{$urandom}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
